// File: rtl/counter_prog.sv
// counter_prog: programmable up/down counter with a
// clock-enable prescaler, load, wrap/saturate and status.
module counter_prog #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             sat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             tc,
  output logic             ovf
);

  // One spare bit when PRESCALE = 1 keeps the register legal;
  // it then never leaves 0, so every enabled edge is a step.
  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    psc_q;
  logic [PW-1:0]    psc_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             step_q;
  logic             step_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;

  logic             step_fire;
  logic             at_bound;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;

  // A step is due when the prescaler reaches its last phase.
  always_comb begin
    step_fire = en && (psc_q == PSC_LAST);
  end

  // Loaded value is clamped into the 0..max_val range.
  always_comb begin
    load_clamped = load_val;
    if (load_val > max_val) begin
      load_clamped = max_val;
    end
  end

  // Candidate count and boundary flag for a step this edge.
  // Boundary test comes first, so 2^WIDTH is never reached.
  always_comb begin
    step_val = count_q;
    at_bound = 1'b0;
    if (up) begin
      if (count_q >= max_val) begin
        at_bound = 1'b1;
        step_val = sat ? max_val : '0;
      end else begin
        step_val = count_q + WIDTH'(1);
      end
    end else begin
      if (count_q == '0) begin
        at_bound = 1'b1;
        step_val = sat ? '0 : max_val;
      end else if (count_q > max_val) begin
        step_val = max_val;
      end else begin
        step_val = count_q - WIDTH'(1);
      end
    end
  end

  // Prescaler: cleared by load, holds while en is low.
  always_comb begin
    psc_d = psc_q;
    if (load) begin
      psc_d = '0;
    end else if (en) begin
      if (psc_q == PSC_LAST) begin
        psc_d = '0;
      end else begin
        psc_d = psc_q + PW'(1);
      end
    end
  end

  // Count and status next-state: load beats step beats hold;
  // a boundary setting ovf beats a same-cycle clear.
  always_comb begin
    count_d = count_q;
    step_d  = 1'b0;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (load) begin
      count_d = load_clamped;
    end else if (step_fire) begin
      count_d = step_val;
      step_d  = 1'b1;
      tc_d    = at_bound;
      if (at_bound) begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_q   <= '0;
      count_q <= '0;
      step_q  <= 1'b0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
      step_q  <= step_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_counter_prog.sv
// tb_counter_prog: scoreboard bench for counter_prog,
// one 4-bit/PRESCALE=1 and one 8-bit/PRESCALE=4 instance.
module tb_counter_prog;

  typedef struct packed {
    logic [7:0] count;
    logic       step;
    logic       tc;
    logic       ovf;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_en, a_up, a_load, a_sat, a_clr;
  logic [3:0] a_lv, a_mv, a_count;
  logic       a_step, a_tc, a_ovf;

  logic       b_en, b_up, b_load, b_sat, b_clr;
  logic [7:0] b_lv, b_mv, b_count;
  logic       b_step, b_tc, b_ovf;

  obs_t obs_a, obs_b;
  assign obs_a = {4'b0, a_count, a_step, a_tc, a_ovf};
  assign obs_b = {b_count, b_step, b_tc, b_ovf};

  obs_t sb[$];
  obs_t got, want;
  int   n_run  = 0;
  int   n_fail = 0;

  counter_prog #(.WIDTH(4), .PRESCALE(1)) u_a (
    .clk(clk), .reset(reset), .en(a_en), .up(a_up),
    .load(a_load), .load_val(a_lv), .max_val(a_mv),
    .sat(a_sat), .clr_ovf(a_clr), .count(a_count),
    .step(a_step), .tc(a_tc), .ovf(a_ovf)
  );

  counter_prog #(.WIDTH(8), .PRESCALE(4)) u_b (
    .clk(clk), .reset(reset), .en(b_en), .up(b_up),
    .load(b_load), .load_val(b_lv), .max_val(b_mv),
    .sat(b_sat), .clr_ovf(b_clr), .count(b_count),
    .step(b_step), .tc(b_tc), .ovf(b_ovf)
  );

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    reset = 1'b1;
    a_en = 1; a_up = 1; a_load = 0; a_sat = 0; a_clr = 0;
    a_lv = 4'd0; a_mv = 4'd15;
    b_en = 1; b_up = 1; b_load = 0; b_sat = 0; b_clr = 0;
    b_lv = 8'd0; b_mv = 8'd255;
    #2;
    n_run++;
    if (obs_a !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got %h want 0", obs_a);
    end
    n_run++;
    if (obs_b !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got %h want 0", obs_b);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_run++;
    if (obs_a !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got %h want 0", obs_a);
    end
  endtask

  task automatic test_free_run();
    obs_t e;
    for (int k = 1; k <= 18; k++) begin
      e.count = 8'(k % 16);
      e.step  = 1'b1;
      e.tc    = (k == 16);
      e.ovf   = (k >= 16);
      sb.push_back(e);
      @(posedge clk); #1;
      got = obs_a; want = sb.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL free_run[%0d]: got %h want %h",
                 k, got, want);
      end
    end
  endtask

  task automatic test_mod_down();
    obs_t e;
    int c;
    a_load = 1; a_lv = 4'd0; a_mv = 4'd9;
    a_up = 0; a_clr = 1;
    e = '{count: 8'd0, step: 0, tc: 0, ovf: 0};
    sb.push_back(e);
    @(posedge clk); #1;
    got = obs_a; want = sb.pop_front();
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL down_load: got %h want %h", got, want);
    end
    a_load = 0; a_clr = 0;
    c = 0;
    for (int k = 1; k <= 11; k++) begin
      e.tc    = (c == 0);
      c       = (c == 0) ? 9 : c - 1;
      e.count = 8'(c);
      e.step  = 1'b1;
      e.ovf   = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      got = obs_a; want = sb.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL down[%0d]: got %h want %h",
                 k, got, want);
      end
    end
  endtask

  task automatic test_saturate();
    obs_t exp_tbl[12];
    logic [7:0] ctl[12];
    exp_tbl[0]  = '{8'd7, 1'b0, 1'b0, 1'b1};
    exp_tbl[1]  = '{8'd8, 1'b1, 1'b0, 1'b1};
    exp_tbl[2]  = '{8'd9, 1'b1, 1'b0, 1'b1};
    exp_tbl[3]  = '{8'd9, 1'b1, 1'b1, 1'b1};
    exp_tbl[4]  = '{8'd9, 1'b1, 1'b1, 1'b1};
    exp_tbl[5]  = '{8'd9, 1'b0, 1'b0, 1'b0};
    exp_tbl[6]  = '{8'd9, 1'b1, 1'b1, 1'b1};
    exp_tbl[7]  = '{8'd9, 1'b0, 1'b0, 1'b0};
    exp_tbl[8]  = '{8'd0, 1'b0, 1'b0, 1'b0};
    exp_tbl[9]  = '{8'd0, 1'b1, 1'b1, 1'b1};
    exp_tbl[10] = '{8'd0, 1'b1, 1'b1, 1'b1};
    exp_tbl[11] = '{8'd0, 1'b1, 1'b1, 1'b1};
    // ctl = {mv0, up, en, clr, load}
    ctl[0]  = 8'b0_1_1_0_1;
    ctl[1]  = 8'b0_1_1_0_0;
    ctl[2]  = 8'b0_1_1_0_0;
    ctl[3]  = 8'b0_1_1_0_0;
    ctl[4]  = 8'b0_1_1_0_0;
    ctl[5]  = 8'b0_1_0_1_0;
    ctl[6]  = 8'b0_1_1_1_0;
    ctl[7]  = 8'b0_1_0_1_0;
    ctl[8]  = 8'b1_1_1_0_1;
    ctl[9]  = 8'b1_1_1_0_0;
    ctl[10] = 8'b1_1_1_0_0;
    ctl[11] = 8'b1_0_1_0_0;
    a_sat = 1; a_lv = 4'd7;
    for (int i = 0; i < 12; i++) begin
      a_load = ctl[i][0];
      a_clr  = ctl[i][1];
      a_en   = ctl[i][2];
      a_up   = ctl[i][3];
      a_mv   = ctl[i][4] ? 4'd0 : 4'd9;
      if (i == 8) a_lv = 4'd5;
      if (i >= 8) a_sat = 0;
      sb.push_back(exp_tbl[i]);
      @(posedge clk); #1;
      got = obs_a; want = sb.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL sat[%0d]: got %h want %h",
                 i, got, want);
      end
    end
  endtask

  task automatic test_prescaler();
    obs_t e;
    int n, steps;
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    n = 0; steps = 0;
    for (int k = 1; k <= 16; k++) begin
      b_en = !(k >= 10 && k <= 12);
      if (b_en) n++;
      e.step  = b_en && (n % 4 == 0);
      if (e.step) steps++;
      e.count = 8'(steps);
      e.tc    = 1'b0;
      e.ovf   = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      got = obs_b; want = sb.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL psc[%0d]: got %h want %h",
                 k, got, want);
      end
    end
  endtask

  task automatic test_load_clamp();
    obs_t e;
    b_en = 1; b_up = 1; b_sat = 0;
    for (int k = 0; k < 14; k++) begin
      b_load = (k == 0 || k == 4 || k == 5);
      b_lv   = (k == 0) ? 8'd200 : (k == 4) ? 8'd10 : 8'd40;
      b_mv   = (k >= 6) ? 8'd30 : 8'd50;
      b_up   = (k < 6);
      e.tc   = 1'b0;
      e.ovf  = 1'b0;
      e.step = (k == 9 || k == 13);
      e.count = (k < 4) ? 8'd50 : (k == 4) ? 8'd10 :
                (k < 9) ? 8'd40 : (k < 13) ? 8'd30 : 8'd29;
      sb.push_back(e);
      @(posedge clk); #1;
      got = obs_b; want = sb.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL clamp[%0d]: got %h want %h",
                 k, got, want);
      end
    end
    b_load = 0;
  endtask

  task automatic test_async_reset();
    obs_t e;
    b_mv = 8'd50; b_up = 1; b_en = 1;
    for (int k = 0; k < 8; k++) begin
      b_load = (k == 0 || k == 5);
      b_lv   = (k == 0) ? 8'd50 : 8'd5;
      e.step = (k == 4);
      e.tc   = (k == 4);
      e.ovf  = (k >= 4);
      e.count = (k < 4) ? 8'd50 : (k == 4) ? 8'd0 : 8'd5;
      sb.push_back(e);
      @(posedge clk); #1;
      got = obs_b; want = sb.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL pre_rst[%0d]: got %h want %h",
                 k, got, want);
      end
    end
    b_load = 0;
    #2;
    reset = 1'b1;
    #1;
    n_run++;
    if (obs_b !== '0) begin
      n_fail++;
      $display("FAIL async_rst: got %h want 0", obs_b);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      e.step  = (k == 4);
      e.tc    = 1'b0;
      e.ovf   = 1'b0;
      e.count = (k == 4) ? 8'd1 : 8'd0;
      sb.push_back(e);
      @(posedge clk); #1;
      got = obs_b; want = sb.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL post_rst[%0d]: got %h want %h",
                 k, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_mod_down();
    test_saturate();
    test_prescaler();
    test_load_clamp();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_prog.md
# counter_prog

Programmable up/down counter: the parametrised successor to the fixed 4-bit free-running counter. It adds:
- configurable width;
- a runtime modulus (terminal value);
- direction control and synchronous load;
- wrap or saturate mode;
- a built-in clock-enable prescaler;
- terminal-count and sticky-overflow status.

It is the general counting/timing primitive for FPGA designs and ModelSim benches that need timers, dividers or event counters.

## Interface
- WIDTH, 8: counter width in bits, ≥ 2
- PRESCALE, 1: number of enabled clk cycles per count step, ≥ 1; a value of 1 means every enabled cycle is a step
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  count enable; when low, both the counter and the prescaler hold
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value captured on load
- max_val  in  WIDTH  terminal value; the count range is 0..max_val
- sat  in  1  boundary mode: 1 = saturate, 0 = wrap
- clr_ovf  in  1  synchronous clear of ovf
- count  out  WIDTH  current count, registered
- step  out  1  registered one-cycle pulse: a count step occurred last cycle
- tc  out  1  registered one-cycle pulse: last step hit a boundary
- ovf  out  1  sticky flag: a boundary step has occurred since the last clear

## Operation
- Reset values: count = 0, step = 0, tc = 0, ovf = 0, prescaler = 0.
- Priority per edge: reset > load > step > hold.
- **Load:**
  - count <= min(load_val, max_val).
  - Prescaler cleared to 0.
  - step = 0, tc = 0; ovf unaffected, except that clr_ovf is still honoured.
- **Prescaler:**
  - Internal counter psc, $clog2(PRESCALE) bits; when PRESCALE = 1 it is a constant step enable.
  - When en = 1: if psc == PRESCALE-1, psc <= 0 and a step occurs; otherwise psc <= psc+1.
  - When en = 0: psc holds.
- **Step, up = 1:**
  - count < max_val: count + 1.
  - count >= max_val is a boundary:
    - wrap: count <= 0.
    - sat: count <= max_val.
- **Step, up = 0:**
  - count == 0 is a boundary:
    - wrap: count <= max_val.
    - sat: count stays 0.
  - count > max_val (max_val lowered at runtime): count <= max_val, not a boundary.
  - Otherwise: count - 1.
- **Boundary step:**
  - tc pulses on the next cycle.
  - ovf <= 1.
  - In saturate mode, tc pulses on every boundary step, not only the first.
- **max_val = 0:**
  - count is pinned at 0.
  - Every step is a boundary, so tc pulses once per step.
- **ovf:**
  - Set by a boundary step.
  - Cleared by clr_ovf.
  - If both happen in the same cycle, set wins.
- **Wrap-around arithmetic:** modulo 2^WIDTH is never reached, because the boundary test precedes the increment. A max_val of all-ones gives a full-range counter.
- **Live inputs:** up, sat and max_val may change any cycle; they are sampled at the step edge.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- step, tc and the updated count all appear together, 1 cycle after the step edge condition.
- PRESCALE = N with en held high:
  - The first step comes N edges after reset release or after a load.
  - Thereafter one step every N edges.
- load takes effect at the next edge; count shows the loaded value 1 cycle later.
- Asynchronous reset asserted mid-count or mid-prescale clears everything immediately.
- The first step after reset deassertion requires PRESCALE enabled edges.

## Test plan
- **Reset then free-run:** WIDTH = 4, PRESCALE = 1, max_val = 15, up = 1, sat = 0, en = 1, reset high for 20 ns then low.
  - count goes 0, 1, ..., 15, 0.
  - tc pulses exactly once, in the cycle count shows 0 after 15; ovf = 1 from then on.
- **Modulus and down count:** max_val = 9, up = 0, wrap, starting from 0.
  - count goes 9, 8, ..., 0, 9.
  - tc pulses on each 0→9 transition.
- **Saturate:** up = 1, sat = 1, load_val = 7, max_val = 9.
  - count goes 7, 8, 9, 9, 9.
  - tc pulses on each step attempted at 9; clr_ovf then drops ovf to 0 one cycle later.
- **Prescaler:** PRESCALE = 4, en high, then en low for 3 cycles mid-period.
  - step pulses every 4 enabled cycles.
  - The gap stretches to exactly 7 cycles across the en-low window; count is unchanged during it.
- **Load clamp, priority and runtime max change:**
  - load_val = 200 with max_val = 50 → count = 50.
  - load and a step in the same cycle → the load wins, tc = 0.
  - With count = 40, max_val lowered to 30 and a down step → count = 30, no tc.
- **Async reset mid-operation:** reset pulsed asynchronously at count = 5, psc = 2.
  - All outputs read 0 before the next clk edge.
  - The next step comes PRESCALE enabled edges after release.
